accumulate_frame: RTL and testbench

Downstream consumer of the n-bit ripple carry adder. It accumulates a frame of FRAME_LEN unsigned operands into a registered running sum, using one adder_nbit instance as its datapath. It tracks a sticky overflow flag and presents the finished frame total over a valid/ready handshake. It sits between an operand source (valid/ready) and a result sink (valid/ready).

---
 rtl/accum_pkg.sv | 12 +
 rtl/adder_nbit.sv | 27 ++
 rtl/accumulate_frame.sv | 121 ++++++++++++
 tb/tb_accumulate_frame.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - shared state encoding and counter width for the frame accumulator
package accum_pkg;

    localparam int COUNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } accum_state_t;

endpackage

// File: rtl/adder_nbit.sv
// rtl/adder_nbit.sv - n-bit ripple carry adder
// Ports: a, b operands; carry_in; sum (modulo 2^BIT_WIDTH); overflow = unsigned carry-out.
module adder_nbit #(
    parameter int BIT_WIDTH = 8
) (
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 carry_in,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 overflow
);

    logic [BIT_WIDTH:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = carry_in;
        for (int i = 0; i < BIT_WIDTH; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign overflow = carry[BIT_WIDTH];

endmodule

// File: rtl/accumulate_frame.sv
// rtl/accumulate_frame.sv - accumulates FRAME_LEN operands and hands the frame total to a sink
// Ports: clk, n_rst (async low); clear (sync abort); in_valid/in_ready/in_data operand stream;
//        out_valid/out_ready/out_sum/out_overflow result; count = operands accepted this frame.
module accumulate_frame
    import accum_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int FRAME_LEN = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [BIT_WIDTH-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_sum,
    output logic                 out_overflow,
    output logic [COUNT_W-1:0]   count
);

    localparam logic [COUNT_W-1:0] LAST_IDX = COUNT_W'(FRAME_LEN - 1);

    accum_state_t         state_q, state_d;
    logic [BIT_WIDTH-1:0] acc_q, acc_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [BIT_WIDTH-1:0] out_sum_q, out_sum_d;
    logic                 out_overflow_q, out_overflow_d;

    logic [BIT_WIDTH-1:0] add_sum;
    logic                 add_ovf;

    adder_nbit #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_adder (
        .a        (acc_q),
        .b        (in_data),
        .carry_in (1'b0),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // One-cycle bubble that also zeroes the frame state.
                    state_d = ACCUM;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
                ACCUM: begin
                    if (in_valid && in_ready_q) begin
                        acc_d   = add_sum;
                        ovf_d   = ovf_q | add_ovf;
                        count_d = count_q + COUNT_W'(1);
                        if (count_q == LAST_IDX) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Outputs are registered from the next state so they track the state flop exactly.
        in_ready_d     = (state_d == ACCUM);
        out_valid_d    = (state_d == DONE);
        out_sum_d      = (state_d == DONE) ? acc_d : out_sum_q;
        out_overflow_d = (state_d == DONE) ? ovf_d : out_overflow_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            count_q        <= '0;
            ovf_q          <= 1'b0;
            in_ready_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            out_sum_q      <= '0;
            out_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            count_q        <= count_d;
            ovf_q          <= ovf_d;
            in_ready_q     <= in_ready_d;
            out_valid_q    <= out_valid_d;
            out_sum_q      <= out_sum_d;
            out_overflow_q <= out_overflow_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_sum      = out_sum_q;
    assign out_overflow = out_overflow_q;
    assign count        = count_q;

endmodule

// File: tb/tb_accumulate_frame.sv
// tb/tb_accumulate_frame.sv - scoreboard bench for accumulate_frame with FRAME_LEN=4
module tb_accumulate_frame;

    logic       clk;
    logic       n_rst;
    logic       clear;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_overflow;
    logic [7:0] count;

    int checks = 0;
    int errors = 0;

    logic [8:0] sb_q[$];

    accumulate_frame #(
        .BIT_WIDTH (8),
        .FRAME_LEN (4)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_overflow (out_overflow),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: inputs change only just after the rising edge, so at the falling
    // edge out_valid && out_ready is exactly the handshake taken at the next edge.
    always @(negedge clk) begin
        if (n_rst && !clear && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", {23'd0, out_overflow, out_sum}, 32'h1ff);
            end else begin
                logic [8:0] e;
                e = sb_q.pop_front();
                chk("out_sum", {24'd0, out_sum}, {24'd0, e[7:0]});
                chk("out_overflow", {31'd0, out_overflow}, {31'd0, e[8]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_frame(input logic [7:0] s, input logic o);
        sb_q.push_back({o, s});
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (sb_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_timeout", sb_q.size(), 32'd0);
        tick();
    endtask

    initial begin
        n_rst     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;

        // Reset
        tick();
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_sum", {24'd0, out_sum}, 32'd0);
        n_rst = 1'b1;
        tick();
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_count", {24'd0, count}, 32'd0);

        // Nominal frame
        out_ready = 1'b1;
        expect_frame(8'd10, 1'b0);
        put(8'd1); put(8'd2); put(8'd3); put(8'd4);
        chk("nom_latency_valid", {31'd0, out_valid}, 32'd1);
        chk("nom_count_done", {24'd0, count}, 32'd4);
        chk("nom_sum_direct", {24'd0, out_sum}, 32'd10);
        drain();
        chk("nom_valid_cleared", {31'd0, out_valid}, 32'd0);

        // Overflow then clean frame: 200+100 wraps to 44
        expect_frame(8'd44, 1'b1);
        put(8'd200); put(8'd100); put(8'd0); put(8'd0);
        drain();
        expect_frame(8'd4, 1'b0);
        put(8'd1); put(8'd1); put(8'd1); put(8'd1);
        drain();

        // Gaps and backpressure: 3+5+7+9 = 24
        out_ready = 1'b0;
        expect_frame(8'd24, 1'b0);
        while (!in_ready) tick();
        put(8'd3); chk("gap_count1", {24'd0, count}, 32'd1);
        tick();    chk("gap_hold1", {24'd0, count}, 32'd1);
        put(8'd5); chk("gap_count2", {24'd0, count}, 32'd2);
        tick();    chk("gap_hold2", {24'd0, count}, 32'd2);
        put(8'd7); chk("gap_count3", {24'd0, count}, 32'd3);
        tick();    chk("gap_hold3", {24'd0, count}, 32'd3);
        put(8'd9);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_sum", {24'd0, out_sum}, 32'd24);
            chk("bp_count", {24'd0, count}, 32'd4);
            tick();
        end
        chk("bp_pending", sb_q.size(), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_released", {31'd0, out_valid}, 32'd0);
        chk("bp_popped", sb_q.size(), 32'd0);

        // Clear mid-frame drops the partial frame and the operand presented with it
        while (!in_ready) tick();
        put(8'd5); put(8'd6);
        in_valid = 1'b1;
        in_data  = 8'd9;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_in_ready", {31'd0, in_ready}, 32'd0);
        chk("clr_count", {24'd0, count}, 32'd0);
        chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
        expect_frame(8'd28, 1'b0);
        put(8'd7); put(8'd7); put(8'd7); put(8'd7);
        drain();

        // Async reset while a result is pending
        out_ready = 1'b0;
        put(8'd10); put(8'd10); put(8'd10); put(8'd10);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        n_rst = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_sum", {24'd0, out_sum}, 32'd0);
        tick();
        n_rst = 1'b1;
        out_ready = 1'b1;
        expect_frame(8'd10, 1'b0);
        put(8'd1); put(8'd2); put(8'd3); put(8'd4);
        drain();

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
